mat_stream_ctrl: RTL

MAT_STREAM_CTRL -- requirements
Module: mat_stream_ctrl

---
 rtl/mat_stream_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mat_stream_ctrl.sv
// Matrix stream controller: gathers two NxN matrices from an element stream,
// hands them to an external multiplier and streams the product back row-major.
module mat_stream_ctrl #(
    parameter int N       = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    output logic [N*N*DW-1:0] mul_a,
    output logic [N*N*DW-1:0] mul_b,
    output logic              mul_start,
    input  logic              mul_done,
    input  logic [N*N*DW-1:0] mul_s,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err
);
    localparam int NE  = N * N;
    localparam int LDW = $clog2(2 * NE);
    localparam int OCW = (NE > 1) ? $clog2(NE) : 1;
    localparam int WCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_e;

    state_e           state_q, state_d;
    logic [LDW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [OCW-1:0]   out_cnt_q, out_cnt_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [NE*DW-1:0] mat_a_q, mat_a_d;
    logic [NE*DW-1:0] mat_b_q, mat_b_d;
    logic [NE*DW-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic             in_fire, out_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            ld_cnt_q   <= '0;
            out_cnt_q  <= '0;
            wait_cnt_q <= '0;
            mat_a_q    <= '0;
            mat_b_q    <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            out_cnt_q  <= out_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mat_a_q    <= mat_a_d;
            mat_b_q    <= mat_b_d;
            res_q      <= res_d;
            err_q      <= err_d;
        end
    end

    // Output data is forced to zero outside UNLOAD so stale results never leak.
    always_comb begin
        in_ready  = (state_q == LOAD);
        mul_start = (state_q == START);
        out_valid = (state_q == UNLOAD);
        busy      = (state_q != LOAD);
        err       = err_q;
        mul_a     = mat_a_q;
        mul_b     = mat_b_q;
        out_data  = '0;
        out_last  = 1'b0;
        if (state_q == UNLOAD) begin
            for (int k = 0; k < NE; k++) begin
                if (out_cnt_q == OCW'(k)) begin
                    out_data = res_q[k*DW +: DW];
                end
            end
            out_last = (out_cnt_q == OCW'(NE - 1));
        end
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
    end

    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        out_cnt_d  = out_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mat_a_d    = mat_a_q;
        mat_b_d    = mat_b_q;
        res_d      = res_q;
        err_d      = err_q;

        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    for (int k = 0; k < NE; k++) begin
                        if (ld_cnt_q == LDW'(k)) begin
                            mat_a_d[k*DW +: DW] = in_data;
                        end
                        if (ld_cnt_q == LDW'(NE + k)) begin
                            mat_b_d[k*DW +: DW] = in_data;
                        end
                    end
                    if (ld_cnt_q == LDW'(2 * NE - 1)) begin
                        ld_cnt_d = '0;
                        state_d  = START;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end
            START: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // A done seen on the final allowed cycle still wins over the timeout.
                if (mul_done) begin
                    res_d      = mul_s;
                    wait_cnt_d = '0;
                    state_d    = UNLOAD;
                end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = LOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            UNLOAD: begin
                if (out_fire) begin
                    if (out_last) begin
                        out_cnt_d = '0;
                        state_d   = LOAD;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

endmodule
